// File: rtl/axi4_master_bridge.sv
// axi4_master_bridge: converts a one-request-at-a-time CPU request/response
// interface into AXI4 INCR read bursts and single-beat AXI4 writes.
// Only one transaction is ever outstanding.
module axi4_master_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   // CPU request side
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_len,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_wstrb,
   // CPU response side
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_last,
   output logic              resp_err,
   // AXI4 read address channel
   output logic              arvalid,
   input  logic              arready,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   // AXI4 read data channel
   input  logic              rvalid,
   output logic              rready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   // AXI4 write address channel
   output logic              awvalid,
   input  logic              awready,
   output logic [ADDR_W-1:0] awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   // AXI4 write data channel
   output logic              wvalid,
   input  logic              wready,
   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   output logic              wlast,
   // AXI4 write response channel
   input  logic              bvalid,
   output logic              bready,
   input  logic [1:0]        bresp
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AWW  = 3'd3,
      ST_B    = 3'd4
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_len;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_wstrb;
   logic [7:0]        r_cnt;
   logic              r_aw_done;
   logic              r_w_done;

   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_r_over;
   logic              w_unused;

   // Low response bits only distinguish OKAY/EXOKAY and SLVERR/DECERR subtypes.
   assign w_unused = &{1'b0, rresp[0], bresp[0]};

   // Fixed burst shape: 4-byte beats, INCR, single-beat writes.
   assign arsize  = 3'b010;
   assign awsize  = 3'b010;
   assign arburst = 2'b01;
   assign awburst = 2'b01;
   assign awlen   = 8'd0;
   assign wlast   = 1'b1;

   // Write-channel handshakes count only while that channel is still pending.
   assign w_aw_hs  = (r_state == ST_AWW) && !r_aw_done && awready;
   assign w_w_hs   = (r_state == ST_AWW) && !r_w_done && wready;
   // Beat counter at or past the last requested beat (covers extra beats).
   assign w_r_over = (r_cnt >= r_len);

   // Per-state output decode; everything not owned by the current state is 0.
   always_comb begin
      req_ready  = (r_state == ST_IDLE) && reset;
      arvalid    = 1'b0;
      araddr     = '0;
      arlen      = '0;
      rready     = 1'b0;
      awvalid    = 1'b0;
      awaddr     = '0;
      wvalid     = 1'b0;
      wdata      = '0;
      wstrb      = '0;
      bready     = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_last  = 1'b0;
      resp_err   = 1'b0;
      case (r_state)
         ST_AR: begin
            arvalid = 1'b1;
            araddr  = r_addr;
            arlen   = r_len;
         end
         ST_R: begin
            rready     = resp_ready;
            resp_valid = rvalid;
            resp_data  = rdata;
            resp_last  = rlast;
            resp_err   = rresp[1] | (rlast && (r_cnt != r_len)) | (w_r_over && !rlast);
         end
         ST_AWW: begin
            awvalid = !r_aw_done;
            awaddr  = r_addr;
            wvalid  = !r_w_done;
            wdata   = r_wdata;
            wstrb   = r_wstrb;
         end
         ST_B: begin
            bready     = resp_ready;
            resp_valid = bvalid;
            resp_last  = 1'b1;
            resp_err   = bresp[1];
         end
         default: ;
      endcase
   end

   // Transaction FSM with request latches, beat counter and write-channel flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_len     <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_cnt     <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_aw_done <= 1'b0;
               r_w_done  <= 1'b0;
               if (req_valid) begin
                  r_addr  <= req_addr;
                  r_len   <= req_len;
                  r_wdata <= req_wdata;
                  r_wstrb <= req_wstrb;
                  r_state <= req_write ? ST_AWW : ST_AR;
               end
            end
            ST_AR: begin
               if (arready) begin
                  r_cnt   <= '0;
                  r_state <= ST_R;
               end
            end
            ST_R: begin
               if (rvalid && resp_ready) begin
                  if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
                  if (rlast) r_state <= ST_IDLE;
               end
            end
            ST_AWW: begin
               if (w_aw_hs) r_aw_done <= 1'b1;
               if (w_w_hs)  r_w_done  <= 1'b1;
               if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= ST_B;
            end
            ST_B: begin
               if (bvalid && resp_ready) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Testbench for axi4_master_bridge: directed scenarios plus randomized
// reads/writes; expected response beats go into a scoreboard queue and a
// separate monitor compares them against every accepted response beat.
module tb_axi4_master_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [7:0]  req_len = '0;
   logic [3:0]  req_wstrb = '0;
   logic        resp_valid, resp_ready = 1'b0, resp_last, resp_err;
   logic [31:0] resp_data;
   logic        arvalid, arready = 1'b0;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid = 1'b0, rready, rlast = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        awvalid, awready = 1'b0;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready = 1'b0, wlast;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid = 1'b0, bready;
   logic [1:0]  bresp = '0;

   always #5 clock = ~clock;

   axi4_master_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_last(resp_last), .resp_err(resp_err),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        err;
   } beat_t;

   beat_t    exp_q[$];
   beat_t    mon_e;
   int       checks = 0;
   int       errors = 0;
   bit [0:5] pat = 6'b101101;

   task automatic check1(input string name, input logic act, input logic expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic finish_sim();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout, got no progress expected completion at %0t", name, $time);
      finish_sim();
   endtask

   // Reference rule for a read beat: i is the beat index in the burst.
   function automatic logic exp_rerr(input int i, input int len, input logic last, input logic slverr);
      int k;
      k = (i > 255) ? 255 : i;
      return slverr | (last && (k != len)) | ((k >= len) && !last);
   endfunction

   // Scoreboard monitor: every accepted response beat must match the oldest expectation.
   always @(negedge clock) begin
      if (reset && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got beat %h expected no beat at %0t", resp_data, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check32("sb_data", resp_data, mon_e.data);
            check1("sb_last", resp_last, mon_e.last);
            check1("sb_err", resp_err, mon_e.err);
         end
      end
   end

   task automatic issue_req(input logic wr, input logic [31:0] a, input logic [7:0] l,
                            input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_wdata = d; req_wstrb = s;
      @(negedge clock);
      while (!req_ready) begin
         n++;
         if (n > 20) timeout("req_ready");
         @(posedge clock); #1;
         @(negedge clock);
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_len   = 8'($urandom);
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      req_write = 1'($urandom);
   endtask

   task automatic do_read(input logic [31:0] a, input int len, input int nsend, input int ar_dly,
                          input logic use_pat, input logic fixed, input logic [31:0] base,
                          input int err_beat, input int rst_beat);
      int          i = 0;
      int          cyc = 0;
      logic        hs;
      logic [31:0] d;
      issue_req(1'b0, a, 8'(len), $urandom, 4'($urandom));
      for (int c = 0; c <= ar_dly; c++) begin
         arready    = (c == ar_dly);
         resp_ready = 1'($urandom);
         @(negedge clock);
         check1("arvalid_hi", arvalid, 1'b1);
         check32("araddr", araddr, a);
         check32("arlen", {24'd0, arlen}, 32'(len));
         @(posedge clock); #1;
      end
      arready = 1'b0;
      while (i < nsend) begin
         if (cyc > 400) timeout("r_beats");
         rvalid     = use_pat ? 1'b1 : ($urandom_range(0, 3) != 0);
         d          = fixed ? base + 32'(i) : $urandom;
         rdata      = d;
         rresp      = {(i == err_beat), 1'($urandom)};
         rlast      = (i == nsend - 1);
         resp_ready = use_pat ? pat[cyc % 6] : 1'($urandom);
         if (i == rst_beat) begin
            rvalid = 1'b1;
            #2 reset = 1'b0;
            #1;
            check1("rst_arvalid", arvalid, 1'b0);
            check1("rst_awvalid", awvalid, 1'b0);
            check1("rst_wvalid", wvalid, 1'b0);
            check1("rst_rready", rready, 1'b0);
            check1("rst_bready", bready, 1'b0);
            check1("rst_req_ready", req_ready, 1'b0);
            check1("rst_resp_valid", resp_valid, 1'b0);
            exp_q.delete();
            @(posedge clock); #1;
            @(posedge clock); #1;
            rvalid = 1'b0;
            rlast  = 1'b0;
            reset  = 1'b1;
            @(negedge clock);
            check1("req_ready_after_rst", req_ready, 1'b1);
            @(posedge clock); #1;
            return;
         end
         hs = rvalid && resp_ready;
         if (hs) exp_q.push_back('{d, rlast, exp_rerr(i, len, rlast, rresp[1])});
         @(negedge clock);
         if (cyc == 0) check1("arvalid_one_cycle", arvalid, 1'b0);
         check1("rready_mirror", rready, resp_ready);
         check1("r_resp_valid", resp_valid, rvalid);
         @(posedge clock); #1;
         if (hs) i++;
         cyc++;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      @(negedge clock);
      check1("req_ready_after_r", req_ready, 1'b1);
      check32("sb_drain_r", 32'(exp_q.size()), 32'd0);
      @(posedge clock); #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] br);
      int   last_c;
      logic hs;
      last_c = (aw_dly > w_dly) ? aw_dly : w_dly;
      issue_req(1'b1, a, 8'($urandom), d, s);
      for (int c = 0; c <= last_c; c++) begin
         awready = (c == aw_dly);
         wready  = (c == w_dly);
         @(negedge clock);
         check1("awvalid", awvalid, (c <= aw_dly));
         check1("wvalid", wvalid, (c <= w_dly));
         if (c <= aw_dly) check32("awaddr", awaddr, a);
         if (c <= w_dly) begin
            check32("wdata", wdata, d);
            check32("wstrb", {28'd0, wstrb}, {28'd0, s});
         end
         @(posedge clock); #1;
      end
      awready = 1'b0;
      wready  = 1'b0;
      for (int c = 0; ; c++) begin
         if (c > 50) timeout("b_resp");
         bvalid     = (c >= b_dly);
         bresp      = br;
         resp_ready = (c > b_dly + 2) ? 1'b1 : 1'($urandom);
         hs         = bvalid && resp_ready;
         if (hs) exp_q.push_back('{32'd0, 1'b1, br[1]});
         @(negedge clock);
         check1("b_awvalid_low", awvalid, 1'b0);
         check1("b_wvalid_low", wvalid, 1'b0);
         check1("bready_mirror", bready, resp_ready);
         check1("b_resp_valid", resp_valid, bvalid);
         @(posedge clock); #1;
         if (hs) break;
      end
      bvalid = 1'b0;
      @(negedge clock);
      check1("req_ready_after_b", req_ready, 1'b1);
      check32("sb_drain_b", 32'(exp_q.size()), 32'd0);
      @(posedge clock); #1;
   endtask

   initial begin
      #400000;
      checks++;
      errors++;
      $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
      finish_sim();
   end

   initial begin
      int len;
      int nsend;
      // Reset state, with slave-side valids and resp_ready driven high to expose leaks.
      rvalid = 1'b1; bvalid = 1'b1; resp_ready = 1'b1; req_valid = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check1("reset_req_ready", req_ready, 1'b0);
      check1("reset_arvalid", arvalid, 1'b0);
      check1("reset_awvalid", awvalid, 1'b0);
      check1("reset_wvalid", wvalid, 1'b0);
      check1("reset_rready", rready, 1'b0);
      check1("reset_bready", bready, 1'b0);
      check1("reset_resp_valid", resp_valid, 1'b0);
      check32("const_sizes", {26'd0, arsize, awsize}, {26'd0, 3'b010, 3'b010});
      check32("const_bursts", {28'd0, arburst, awburst}, {28'd0, 2'b01, 2'b01});
      check32("const_awlen_wlast", {23'd0, awlen, wlast}, 32'd1);
      @(posedge clock); #1;
      rvalid = 1'b0; bvalid = 1'b0; resp_ready = 1'b0; req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      check1("req_ready_after_release", req_ready, 1'b1);
      @(posedge clock); #1;

      // Single read
      do_read(32'h3000_0000, 0, 1, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, -1, -1);
      // Burst read with resp_ready stalls
      do_read(32'h3000_0100, 3, 4, 0, 1'b1, 1'b1, 32'h0000_00A0, -1, -1);
      // Write with skewed channels
      do_write(32'h1000_0000, 32'h41, 4'b0001, 3, 1, 0, 2'b00);
      // Same-cycle AW/W handshake, SLVERR response
      do_write(32'h1000_0004, 32'h1234_5678, 4'b1111, 0, 0, 1, 2'b10);
      // Next request accepted after the error
      do_read(32'h8000_0000, 1, 2, 1, 1'b0, 1'b0, 32'd0, -1, -1);
      // Early rlast on beat 2 of a 4-beat burst
      do_read(32'h3000_0200, 3, 3, 0, 1'b0, 1'b0, 32'd0, -1, -1);
      // Overlong burst: beats past len without rlast
      do_read(32'h3000_0300, 1, 4, 0, 1'b0, 1'b0, 32'd0, -1, -1);
      // Slave error mid-burst
      do_read(32'h3000_0400, 2, 3, 2, 1'b0, 1'b0, 32'd0, 1, -1);
      // Reset in the middle of an 8-beat burst, then a fresh read
      do_read(32'h8000_1000, 7, 8, 0, 1'b0, 1'b0, 32'd0, -1, 3);
      do_read(32'h8000_2000, 2, 3, 0, 1'b0, 1'b0, 32'd0, -1, -1);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 1) == 1) begin
            do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom));
         end else begin
            len   = $urandom_range(0, 6);
            nsend = len + 1;
            if ($urandom_range(0, 3) == 0) nsend = len + 2;
            if ($urandom_range(0, 3) == 0 && len > 0) nsend = len;
            do_read($urandom, len, nsend, $urandom_range(0, 3), 1'b0, 1'b0, 32'd0,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(0, nsend - 1) : -1, -1);
         end
      end

      repeat (2) @(posedge clock);
      check32("sb_final_drain", 32'(exp_q.size()), 32'd0);
      finish_sim();
   end

endmodule
